shared_counter_sched: RTL and testbench
=======================================

// Module: shared_counter_sched
// PURPOSE
// Round-robin scheduler sharing one counter register among N requesters. Each granted request
//   applies one op (INC/ADD/LOAD/READ) to the counter and returns the pre-op value, i.e.
//   fetch-and-op (same sampling relation as a register loaded from the counter on the same edge).
// Sits between software-visible requesters and the single shared count register.
// PARAMETERS
// N          4   number of requesters (>=2)
// W          8   counter / data width
// RESET_VAL  1   counter value after reset
// PORTS
// clk        in   1        single clock, all state updates on posedge
// rst        in   1        synchronous, active-high reset
// req        in   N        per-requester request; held high with op/data stable until gnt seen
// op         in   N x 2    per-requester op_e: 00 INC, 01 ADD, 10 LOAD, 11 READ
// data       in   N x W    per-requester operand (ADD/LOAD), ignored for INC/READ
// gnt        out  N        one-hot registered grant, high exactly one cycle per accepted request
// rsp_valid  out  1        response strobe, one cycle
// rsp_id     out  clog2(N) index of requester owning the response
// rsp_data   out  W        counter value before the op was applied
// count      out  W        current counter value
// BEHAVIOUR
// Reset (rst high at an edge): gnt=0, rsp_valid=0, rsp_id=0, rsp_data=0, count=RESET_VAL,
//   rr pointer=0, pipeline valid bits cleared; in-flight op is discarded, not committed.
// Edge A (arbitrate): eligible = req & ~gnt (requester granted this cycle is masked, since it
//   drops req only at this same edge). Winner = first eligible index searching ptr, ptr+1, ...
//   mod N. Register gnt=onehot(winner), latch op/data/id, set v1; ptr <= winner+1 mod N.
//   No eligible: gnt=0, v1=0, ptr unchanged.
// Edge B (commit, next edge, end of gnt cycle): if v1: rsp_data<=count (old), rsp_id<=id_q,
//   rsp_valid<=1; count <= INC: count+1 | ADD: count+data_q | LOAD: data_q | READ: count.
//   Arithmetic modulo 2^W, carry discarded, no saturation. rsp_valid<=0 if !v1.
// Latency: req seen at edge k -> gnt high cycle k+1 -> count updated at edge k+1 ->
//   rsp_valid high cycle k+2. Throughput one op per cycle.
// Back-to-back ops commit in grant order; each sees all earlier commits (no lost updates).
// Requester dropping req before gnt: request withdrawn, no side effect. Requester raising req
//   again the cycle after its gnt cycle is eligible normally.
// All requests are pipeline-registered; no combinational path req/op/data -> any output.
// STRUCTURE
// Package shared_counter_pkg: typedef enum logic [1:0] op_e {OP_INC, OP_ADD, OP_LOAD, OP_READ};
//   localparam-free helper function apply_op(count, op, data) returning next count.
// Sub-module rr_arbiter #(N): inputs eligible, ptr; output one-hot winner + any; purely
//   combinational. Pointer register, pipeline regs and counter live in shared_counter_sched.
// TESTING
// 1 Reset: rst high 2 cycles -> count=1, gnt=0, rsp_valid=0; release, no req -> all stay.
// 2 Single INC from req[2] at edge k -> gnt=4'b0100 cycle k+1, count=2 after edge k+1,
//   rsp_valid cycle k+2 with rsp_id=2, rsp_data=1.
// 3 All four req INC held continuously from count=1 -> grants 0,1,2,3,0.. one per cycle,
//   rsp_data 1,2,3,4 in order, count=5 after four commits.
// 4 W=8: LOAD 8'hFE then INC then ADD 8'h03 -> rsp_data FE? no: FE->rsp 1; INC rsp FE,
//   count FF; ADD rsp FF, count 8'h02 (wrap).
// 5 READ from req[1] with count=7 -> rsp_data=7, count stays 7; data ignored.
// 6 rst asserted in the gnt cycle of a LOAD 8'h55 -> count=RESET_VAL, no rsp_valid, ptr=0.

Source files
------------

// File: rtl/shared_counter_pkg.sv
// Shared definitions for the round-robin shared-counter scheduler.
package shared_counter_pkg;

  localparam int unsigned CNT_MAX_W = 32;

  typedef enum logic [1:0] {
    OP_INC  = 2'b00,
    OP_ADD  = 2'b01,
    OP_LOAD = 2'b10,
    OP_READ = 2'b11
  } op_e;

  // Next counter value; callers truncate to their own width, so the sum wraps modulo 2^W.
  function automatic logic [CNT_MAX_W-1:0] apply_op(
    input logic [CNT_MAX_W-1:0] count,
    input op_e                  op,
    input logic [CNT_MAX_W-1:0] data
  );
    logic [CNT_MAX_W-1:0] nxt;
    case (op)
      OP_INC:  nxt = count + CNT_MAX_W'(1);
      OP_ADD:  nxt = count + data;
      OP_LOAD: nxt = data;
      default: nxt = count;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/shared_counter_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible index at or after ptr, wrapping mod N.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         win,
  output logic                 any
);

  localparam int unsigned PW = $clog2(N);

  always_comb begin
    win = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned idx;
      idx = 32'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!any && eligible[idx[PW-1:0]]) begin
        win[idx[PW-1:0]] = 1'b1;
        any              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_counter_sched.sv
// Round-robin scheduler sharing one counter among N requesters (fetch-and-op, 2-stage pipe).
module shared_counter_sched
  import shared_counter_pkg::*;
#(
  parameter int unsigned    N         = 4,
  parameter int unsigned    W         = 8,
  parameter logic [W-1:0]   RESET_VAL = W'(1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [2*N-1:0]       op,
  input  logic [W*N-1:0]       data,
  output logic [N-1:0]         gnt,
  output logic                 rsp_valid,
  output logic [$clog2(N)-1:0] rsp_id,
  output logic [W-1:0]         rsp_data,
  output logic [W-1:0]         count
);

  localparam int unsigned PW = $clog2(N);

  logic [N-1:0]  eligible;
  logic [N-1:0]  win;
  logic          any;
  logic [PW-1:0] win_idx;
  op_e           win_op;
  logic [W-1:0]  win_data;

  logic [N-1:0]  gnt_q;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          v1_q;
  op_e           op_q;
  logic [W-1:0]  data_q;
  logic [PW-1:0] id_q;

  logic [W-1:0]  count_q, count_d;
  logic          rsp_valid_q;
  logic [PW-1:0] rsp_id_q;
  logic [W-1:0]  rsp_data_q;

  logic [CNT_MAX_W-1:0] cnt_ext, dat_ext, nxt_wide;
  logic                 nxt_unused;

  // The requester granted this cycle still shows req until the edge ending its gnt cycle.
  assign eligible = req & ~gnt_q;

  rr_arbiter #(.N(N)) u_arb (
    .eligible (eligible),
    .ptr      (ptr_q),
    .win      (win),
    .any      (any)
  );

  always_comb begin
    win_idx  = '0;
    win_op   = OP_INC;
    win_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (win[i]) begin
        win_idx  = PW'(i);
        win_op   = op_e'(op[2*i +: 2]);
        win_data = data[W*i +: W];
      end
    end
    ptr_d = (win_idx == PW'(N-1)) ? '0 : win_idx + PW'(1);
  end

  always_comb begin
    cnt_ext          = '0;
    dat_ext          = '0;
    cnt_ext[W-1:0]   = count_q;
    dat_ext[W-1:0]   = data_q;
    nxt_wide         = apply_op(cnt_ext, op_q, dat_ext);
    count_d          = nxt_wide[W-1:0];
    nxt_unused       = ^nxt_wide;
  end

  // Arbitration stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q  <= '0;
      v1_q   <= 1'b0;
      ptr_q  <= '0;
      op_q   <= OP_INC;
      data_q <= '0;
      id_q   <= '0;
    end else if (any) begin
      gnt_q  <= win;
      v1_q   <= 1'b1;
      ptr_q  <= ptr_d;
      op_q   <= win_op;
      data_q <= win_data;
      id_q   <= win_idx;
    end else begin
      gnt_q  <= '0;
      v1_q   <= 1'b0;
    end
  end

  // Commit stage: response carries the value the counter held before this op.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= RESET_VAL;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else if (v1_q) begin
      count_q     <= count_d;
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= id_q;
      rsp_data_q  <= count_q;
    end else begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign count     = count_q;

endmodule

// File: tb/tb_shared_counter_sched.sv
// Directed, table-driven bench for shared_counter_sched (N=4, W=8, RESET_VAL=1).
module tb_shared_counter_sched;

  localparam logic [1:0] INC = 2'b00;
  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] LD  = 2'b10;
  localparam logic [1:0] RD  = 2'b11;

  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] data;
    logic [3:0]  e_gnt;
    logic        e_rv;
    logic [1:0]  e_id;
    logic [7:0]  e_rd;
    logic [7:0]  e_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic [7:0]  count;

  int checks = 0;
  int errors = 0;

  vec_t tbl [27];

  shared_counter_sched #(.N(4), .W(8), .RESET_VAL(8'd1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op),
    .data      (data),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [3:0] rq, logic [7:0] o, logic [31:0] d,
                              logic [3:0] g, logic rv, logic [1:0] id, logic [7:0] rd,
                              logic [7:0] c);
    vec_t v;
    v.rst = r; v.req = rq; v.op = o; v.data = d;
    v.e_gnt = g; v.e_rv = rv; v.e_id = id; v.e_rd = rd; v.e_cnt = c;
    return v;
  endfunction

  task automatic chk(input string nm, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, step, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int step);
    rst  = v.rst;
    req  = v.req;
    op   = v.op;
    data = v.data;
    @(posedge clk);
    #1;
    chk("gnt",       step, 32'(gnt),       32'(v.e_gnt));
    chk("rsp_valid", step, 32'(rsp_valid), 32'(v.e_rv));
    chk("rsp_id",    step, 32'(rsp_id),    32'(v.e_id));
    chk("rsp_data",  step, 32'(rsp_data),  32'(v.e_rd));
    chk("count",     step, 32'(count),     32'(v.e_cnt));
  endtask

  initial begin
    // Reset and idle
    tbl[0]  = mk(1, 4'b0000, 8'h00, 32'h0, 4'b0000, 0, 0, 8'h00, 8'h01);
    tbl[1]  = mk(1, 4'b0000, 8'h00, 32'h0, 4'b0000, 0, 0, 8'h00, 8'h01);
    tbl[2]  = mk(0, 4'b0000, 8'h00, 32'h0, 4'b0000, 0, 0, 8'h00, 8'h01);
    tbl[3]  = mk(0, 4'b0000, 8'h00, 32'h0, 4'b0000, 0, 0, 8'h00, 8'h01);
    // Single INC from requester 2
    tbl[4]  = mk(0, 4'b0100, 8'h00, 32'h0, 4'b0100, 0, 0, 8'h00, 8'h01);
    tbl[5]  = mk(0, 4'b0100, 8'h00, 32'h0, 4'b0000, 1, 2, 8'h01, 8'h02);
    tbl[6]  = mk(0, 4'b0000, 8'h00, 32'h0, 4'b0000, 0, 2, 8'h01, 8'h02);
    // Re-reset, then all four INC held: grants 0,1,2,3,0
    tbl[7]  = mk(1, 4'b0000, 8'h00, 32'h0, 4'b0000, 0, 0, 8'h00, 8'h01);
    tbl[8]  = mk(0, 4'b1111, 8'h00, 32'h0, 4'b0001, 0, 0, 8'h00, 8'h01);
    tbl[9]  = mk(0, 4'b1111, 8'h00, 32'h0, 4'b0010, 1, 0, 8'h01, 8'h02);
    tbl[10] = mk(0, 4'b1111, 8'h00, 32'h0, 4'b0100, 1, 1, 8'h02, 8'h03);
    tbl[11] = mk(0, 4'b1111, 8'h00, 32'h0, 4'b1000, 1, 2, 8'h03, 8'h04);
    tbl[12] = mk(0, 4'b1111, 8'h00, 32'h0, 4'b0001, 1, 3, 8'h04, 8'h05);
    tbl[13] = mk(0, 4'b0000, 8'h00, 32'h0, 4'b0000, 1, 0, 8'h05, 8'h06);
    tbl[14] = mk(0, 4'b0000, 8'h00, 32'h0, 4'b0000, 0, 0, 8'h05, 8'h06);
    // LOAD FE (r1), INC (r2), ADD 03 (r3) with wrap; ptr=1
    tbl[15] = mk(0, 4'b1110, {ADD, INC, LD, INC}, 32'h03_00_FE_00, 4'b0010, 0, 0, 8'h05, 8'h06);
    tbl[16] = mk(0, 4'b1110, {ADD, INC, LD, INC}, 32'h03_00_FE_00, 4'b0100, 1, 1, 8'h06, 8'hFE);
    tbl[17] = mk(0, 4'b1100, {ADD, INC, LD, INC}, 32'h03_00_FE_00, 4'b1000, 1, 2, 8'hFE, 8'hFF);
    tbl[18] = mk(0, 4'b1000, {ADD, INC, LD, INC}, 32'h03_00_FE_00, 4'b0000, 1, 3, 8'hFF, 8'h02);
    tbl[19] = mk(0, 4'b0000, 8'h00, 32'h0, 4'b0000, 0, 3, 8'hFF, 8'h02);
    // LOAD 07 (r0), then READ (r1) with a non-zero operand that must be ignored
    tbl[20] = mk(0, 4'b0011, {INC, INC, RD, LD}, 32'h0000_AA07, 4'b0001, 0, 3, 8'hFF, 8'h02);
    tbl[21] = mk(0, 4'b0011, {INC, INC, RD, LD}, 32'h0000_AA07, 4'b0010, 1, 0, 8'h02, 8'h07);
    tbl[22] = mk(0, 4'b0010, {INC, INC, RD, LD}, 32'h0000_AA07, 4'b0000, 1, 1, 8'h07, 8'h07);
    tbl[23] = mk(0, 4'b0000, 8'h00, 32'h0, 4'b0000, 0, 1, 8'h07, 8'h07);
    // r1 withdraws its ADD before being granted; only r2's INC commits
    tbl[24] = mk(0, 4'b0110, {INC, INC, ADD, INC}, 32'h0000_1000, 4'b0100, 0, 1, 8'h07, 8'h07);
    tbl[25] = mk(0, 4'b0100, {INC, INC, INC, INC}, 32'h0, 4'b0000, 1, 2, 8'h07, 8'h08);
    tbl[26] = mk(0, 4'b0000, 8'h00, 32'h0, 4'b0000, 0, 2, 8'h07, 8'h08);

    rst = 1'b1; req = '0; op = '0; data = '0;

    for (int i = 0; i < 27; i++) apply(tbl[i], i);

    // Reset lands in the gnt cycle of a LOAD 55: op discarded, pointer back to 0.
    // ptr is 3 here, so r0 wins and ptr moves to 1.
    apply(mk(0, 4'b0001, {INC, INC, INC, LD}, 32'h55, 4'b0001, 0, 2, 8'h07, 8'h08), 100);
    apply(mk(1, 4'b0001, {INC, INC, INC, LD}, 32'h55, 4'b0000, 0, 0, 8'h00, 8'h01), 101);
    // With ptr=0 r0 wins over r1; a stale ptr=1 would pick r1.
    apply(mk(0, 4'b0011, 8'h00, 32'h0, 4'b0001, 0, 0, 8'h00, 8'h01), 102);
    apply(mk(0, 4'b0011, 8'h00, 32'h0, 4'b0010, 1, 0, 8'h01, 8'h02), 103);
    apply(mk(0, 4'b0000, 8'h00, 32'h0, 4'b0000, 1, 1, 8'h02, 8'h03), 104);
    apply(mk(0, 4'b0000, 8'h00, 32'h0, 4'b0000, 0, 1, 8'h02, 8'h03), 105);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
